// File: rtl/cp0_exception_unit.sv
// CP0 register file and precise-exception commit for the MEM stage of the 5-stage MIPS core.
// CP0 state is registered; flush, redirect PC and mfc0 read data are combinational.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallM,
  input  logic        ValidM,
  input  logic [31:0] PCM,
  input  logic        DelaySlotM,
  input  logic        SyscallM,
  input  logic        BreakM,
  input  logic        ReserveM,
  input  logic        EretM,
  input  logic        OverflowM,
  input  logic        AdelIfM,
  input  logic        AdelM,
  input  logic        AdesM,
  input  logic [31:0] BadAddrM,
  input  logic        CP0WriteM,
  input  logic [4:0]  CP0WaddrM,
  input  logic [31:0] CP0WdataM,
  input  logic [4:0]  CP0RaddrE,
  output logic [31:0] CP0RdataE,
  input  logic [5:0]  HwInt,
  output logic        ExceptFlush,
  output logic [31:0] ExceptPC,
  output logic [31:0] EpcOut,
  output logic [31:0] StatusOut
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] badVAddr, count, compare, epc;
  logic        tick;
  logic [7:0]  statusIm;
  logic        statusExl, statusIe;
  logic        causeBd, causeTi;
  logic [5:0]  causeIpHw;
  logic [1:0]  causeIpSw;
  logic [4:0]  causeExcCode;

  logic [31:0] status, cause;
  logic        take, intPending;
  logic        excTaken, excBadPc, excBadData;
  logic [4:0]  excCode;
  logic        excFire, eretFire, cp0Write;

  // Only the writable fields are stored; BEV is a constant taken from the reset value.
  assign status = {9'd0, STATUS_RST[22], 6'd0, statusIm, 6'd0, statusExl, statusIe};
  assign cause  = {causeBd, causeTi, 14'd0, causeIpHw, causeIpSw, 1'b0, causeExcCode, 2'b00};

  assign take       = ValidM & ~StallM;
  assign intPending = statusIe & ~statusExl & (|({causeIpHw, causeIpSw} & statusIm));

  always_comb begin
    excTaken   = 1'b1;
    excBadPc   = 1'b0;
    excBadData = 1'b0;
    excCode    = 5'h00;
    if (intPending) begin
      excCode = 5'h00;
    end else if (AdelIfM) begin
      excCode  = 5'h04;
      excBadPc = 1'b1;
    end else if (ReserveM) begin
      excCode = 5'h0a;
    end else if (OverflowM) begin
      excCode = 5'h0c;
    end else if (SyscallM) begin
      excCode = 5'h08;
    end else if (BreakM) begin
      excCode = 5'h09;
    end else if (AdelM) begin
      excCode    = 5'h04;
      excBadData = 1'b1;
    end else if (AdesM) begin
      excCode    = 5'h05;
      excBadData = 1'b1;
    end else begin
      excTaken = 1'b0;
    end
  end

  // Any exception (interrupt included) outranks eret and suppresses a concurrent mtc0.
  assign excFire     = take & excTaken;
  assign eretFire    = take & EretM & ~excTaken;
  assign cp0Write    = take & CP0WriteM & ~excTaken;
  assign ExceptFlush = excFire | eretFire;
  assign ExceptPC    = eretFire ? epc : EXC_VECTOR;
  assign EpcOut      = epc;
  assign StatusOut   = status;

  always_comb begin
    CP0RdataE = 32'd0;
    case (CP0RaddrE)
      REG_BADVADDR: CP0RdataE = badVAddr;
      REG_COUNT:    CP0RdataE = count;
      REG_COMPARE:  CP0RdataE = compare;
      REG_STATUS:   CP0RdataE = status;
      REG_CAUSE:    CP0RdataE = cause;
      REG_EPC:      CP0RdataE = epc;
      default:      CP0RdataE = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badVAddr     <= 32'd0;
      count        <= 32'd0;
      compare      <= 32'd0;
      epc          <= 32'd0;
      tick         <= 1'b0;
      statusIm     <= STATUS_RST[15:8];
      statusExl    <= STATUS_RST[1];
      statusIe     <= STATUS_RST[0];
      causeBd      <= 1'b0;
      causeTi      <= 1'b0;
      causeIpHw    <= 6'd0;
      causeIpSw    <= 2'd0;
      causeExcCode <= 5'd0;
    end else begin
      tick <= ~tick;
      if (cp0Write && CP0WaddrM == REG_COUNT)
        count <= CP0WdataM;
      else if (tick)
        count <= count + 32'd1;

      // Clearing through a Compare write takes precedence over a fresh match.
      if (cp0Write && CP0WaddrM == REG_COMPARE)
        causeTi <= 1'b0;
      else if (count == compare)
        causeTi <= 1'b1;

      causeIpHw <= {HwInt[5] | causeTi, HwInt[4:0]};

      if (excFire) begin
        causeExcCode <= excCode;
        statusExl    <= 1'b1;
        if (!statusExl) begin
          epc     <= DelaySlotM ? PCM - 32'd4 : PCM;
          causeBd <= DelaySlotM;
        end
        if (excBadPc)
          badVAddr <= PCM;
        else if (excBadData)
          badVAddr <= BadAddrM;
      end else begin
        if (cp0Write) begin
          case (CP0WaddrM)
            REG_COMPARE: compare <= CP0WdataM;
            REG_STATUS: begin
              statusIm  <= CP0WdataM[15:8];
              statusExl <= CP0WdataM[1];
              statusIe  <= CP0WdataM[0];
            end
            REG_CAUSE:   causeIpSw <= CP0WdataM[9:8];
            REG_EPC:     epc <= CP0WdataM;
            default: ;
          endcase
        end
        if (eretFire)
          statusExl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: directed scenarios plus random traffic, every cycle compared
// against a register-level reference model of CP0 kept in the bench.
module tb_cp0_exception_unit;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam logic [31:0] ST_MASK = 32'h0000_FF03;
  localparam logic [31:0] IPSW_MASK = 32'h0000_0300;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_m, valid_m, delay_slot_m;
  logic [31:0] pc_m, bad_addr_m, cp0_wdata_m;
  logic        syscall_m, break_m, reserve_m, eret_m, overflow_m;
  logic        adel_if_m, adel_m, ades_m, cp0_write_m;
  logic [4:0]  cp0_waddr_m, cp0_raddr_e;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata_e, except_pc, epc_out, status_out;
  logic        except_flush;

  cp0_exception_unit dut (
    .clk(clk), .rst(rst), .StallM(stall_m), .ValidM(valid_m), .PCM(pc_m),
    .DelaySlotM(delay_slot_m), .SyscallM(syscall_m), .BreakM(break_m),
    .ReserveM(reserve_m), .EretM(eret_m), .OverflowM(overflow_m),
    .AdelIfM(adel_if_m), .AdelM(adel_m), .AdesM(ades_m), .BadAddrM(bad_addr_m),
    .CP0WriteM(cp0_write_m), .CP0WaddrM(cp0_waddr_m), .CP0WdataM(cp0_wdata_m),
    .CP0RaddrE(cp0_raddr_e), .CP0RdataE(cp0_rdata_e), .HwInt(hw_int),
    .ExceptFlush(except_flush), .ExceptPC(except_pc), .EpcOut(epc_out),
    .StatusOut(status_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state (whole architectural registers)
  logic [31:0] m_badv, m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tick;
  logic        e_flush, e_eret;
  logic [31:0] e_pc;
  int          e_idx;
  logic [4:0]  exc_codes [8] = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};

  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0; m_cause = 0;
    m_status = 32'h0040_0000; m_tick = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // Pick the highest-priority cause from an ordered table of conditions.
  task automatic model_eval();
    logic conds [8];
    logic int_pend;
    logic take;
    take = valid_m && !stall_m;
    int_pend = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0);
    conds = '{int_pend, adel_if_m, reserve_m, overflow_m, syscall_m, break_m, adel_m, ades_m};
    e_idx = -1;
    if (take)
      for (int i = 7; i >= 0; i--)
        if (conds[i]) e_idx = i;
    e_eret  = take && eret_m && (e_idx < 0);
    e_flush = (e_idx >= 0) || e_eret;
    e_pc    = e_eret ? m_epc : EXC_VEC;
  endtask

  task automatic model_commit();
    logic wr, old_ti, match;
    old_ti = m_cause[30];
    match  = (m_count == m_compare);
    wr = valid_m && !stall_m && cp0_write_m && (e_idx < 0);
    if (wr && cp0_waddr_m == 5'd9) m_count = cp0_wdata_m;
    else m_count = m_count + {31'd0, m_tick};
    m_tick = ~m_tick;
    if (wr && cp0_waddr_m == 5'd11) m_cause[30] = 1'b0;
    else if (match) m_cause[30] = 1'b1;
    m_cause[15:10] = {hw_int[5] | old_ti, hw_int[4:0]};
    if (e_idx >= 0) begin
      m_cause[6:2] = exc_codes[e_idx];
      if (!m_status[1]) begin
        m_epc = delay_slot_m ? pc_m - 32'd4 : pc_m;
        m_cause[31] = delay_slot_m;
      end
      m_status[1] = 1'b1;
      if (e_idx == 1) m_badv = pc_m;
      else if (e_idx >= 6) m_badv = bad_addr_m;
    end else begin
      if (wr) begin
        case (cp0_waddr_m)
          5'd11: m_compare = cp0_wdata_m;
          5'd12: m_status = (m_status & ~ST_MASK) | (cp0_wdata_m & ST_MASK);
          5'd13: m_cause = (m_cause & ~IPSW_MASK) | (cp0_wdata_m & IPSW_MASK);
          5'd14: m_epc = cp0_wdata_m;
          default: ;
        endcase
      end
      if (e_eret) m_status[1] = 1'b0;
    end
  endtask

  // One cycle: inputs are already driven after a falling edge.
  task automatic step();
    #1;
    model_eval();
    exp_q.push_back({31'd0, e_flush});
    exp_q.push_back(e_pc);
    exp_q.push_back(model_read(cp0_raddr_e));
    exp_q.push_back(m_epc);
    exp_q.push_back(m_status);
    check_eq("flush", {31'd0, except_flush}, exp_q.pop_front());
    check_eq("except_pc", except_pc, exp_q.pop_front());
    check_eq("rdata", cp0_rdata_e, exp_q.pop_front());
    check_eq("epc_out", epc_out, exp_q.pop_front());
    check_eq("status_out", status_out, exp_q.pop_front());
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle();
    stall_m = 0; valid_m = 0; delay_slot_m = 0; pc_m = 32'hBFC0_0000; bad_addr_m = 0;
    syscall_m = 0; break_m = 0; reserve_m = 0; eret_m = 0; overflow_m = 0;
    adel_if_m = 0; adel_m = 0; ades_m = 0; cp0_write_m = 0; cp0_waddr_m = 0;
    cp0_wdata_m = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    valid_m = 1; cp0_write_m = 1; cp0_waddr_m = a; cp0_wdata_m = d;
    step();
    idle();
  endtask

  task automatic random_cycle();
    logic [4:0] regs [7];
    regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
    valid_m = ($urandom_range(0, 3) != 0);
    stall_m = ($urandom_range(0, 7) == 0);
    pc_m = $urandom; delay_slot_m = 1'($urandom_range(0, 1));
    bad_addr_m = $urandom;
    syscall_m = ($urandom_range(0, 15) == 0); break_m = ($urandom_range(0, 15) == 0);
    reserve_m = ($urandom_range(0, 15) == 0); eret_m = ($urandom_range(0, 7) == 0);
    overflow_m = ($urandom_range(0, 15) == 0); adel_if_m = ($urandom_range(0, 15) == 0);
    adel_m = ($urandom_range(0, 15) == 0); ades_m = ($urandom_range(0, 15) == 0);
    cp0_write_m = ($urandom_range(0, 2) == 0);
    cp0_waddr_m = regs[$urandom_range(0, 6)];
    cp0_wdata_m = $urandom;
    if (cp0_waddr_m == 5'd9 || cp0_waddr_m == 5'd11) cp0_wdata_m = $urandom_range(0, 40);
    if (cp0_waddr_m == 5'd12 && $urandom_range(0, 1) == 1) cp0_wdata_m[1:0] = 2'b01;
    cp0_raddr_e = regs[$urandom_range(0, 6)];
    hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
    step();
  endtask

  logic [31:0] tmp;
  logic found;

  initial begin
    idle();
    hw_int = 0; cp0_raddr_e = 5'd12; rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();

    // reset state and idle counting
    #1;
    check_eq("rst_status", status_out, 32'h0040_0000);
    check_eq("rst_flush", {31'd0, except_flush}, 32'd0);
    check_eq("rst_pc", except_pc, EXC_VEC);
    check_eq("rst_epc", epc_out, 32'd0);
    cp0_raddr_e = 5'd9;
    repeat (10) begin
      #1 check_eq("idle_flush", {31'd0, except_flush}, 32'd0);
      step();
    end
    #1 check_eq("count_after_idle", cp0_rdata_e, 32'd5);

    // syscall in a delay slot
    idle(); cp0_raddr_e = 5'd13;
    valid_m = 1; syscall_m = 1; pc_m = 32'hBFC0_0100; delay_slot_m = 1;
    #1;
    check_eq("sys_flush", {31'd0, except_flush}, 32'd1);
    check_eq("sys_pc", except_pc, EXC_VEC);
    step();
    idle();
    #1;
    tmp = cp0_rdata_e;
    check_eq("sys_epc", epc_out, 32'hBFC0_00FC);
    check_eq("sys_bd", {31'd0, tmp[31]}, 32'd1);
    check_eq("sys_code", {27'd0, tmp[6:2]}, 32'h08);
    check_eq("sys_exl", {31'd0, status_out[1]}, 32'd1);

    // load address error, then again with EXL already set
    mtc0(5'd12, 32'h0000_0000);
    valid_m = 1; adel_m = 1; bad_addr_m = 32'h8000_0003; pc_m = 32'hBFC0_0200;
    step();
    idle(); cp0_raddr_e = 5'd8;
    #1 check_eq("adel_badv", cp0_rdata_e, 32'h8000_0003);
    check_eq("adel_epc", epc_out, 32'hBFC0_0200);
    cp0_raddr_e = 5'd13;
    #1 tmp = cp0_rdata_e;
    check_eq("adel_code", {27'd0, tmp[6:2]}, 32'h04);
    valid_m = 1; adel_m = 1; bad_addr_m = 32'h8000_0010; pc_m = 32'hBFC0_0300;
    step();
    idle();
    #1 check_eq("adel2_epc_kept", epc_out, 32'hBFC0_0200);

    // timer interrupt
    mtc0(5'd9, 32'd1000);
    mtc0(5'd11, 32'd6);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    cp0_raddr_e = 5'd13;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1 tmp = cp0_rdata_e;
      if (tmp[30]) found = 1;
      else step();
    end
    check_eq("ti_seen", {31'd0, found}, 32'd1);
    cp0_raddr_e = 5'd9;
    #1 check_eq("ti_count", cp0_rdata_e, 32'd6);
    cp0_raddr_e = 5'd13;
    step();
    valid_m = 1; pc_m = 32'hBFC0_0040;
    #1 check_eq("int_flush", {31'd0, except_flush}, 32'd1);
    step();
    idle();
    #1 tmp = cp0_rdata_e;
    check_eq("int_code", {27'd0, tmp[6:2]}, 32'h00);
    mtc0(5'd11, 32'd100);
    #1 tmp = cp0_rdata_e;
    check_eq("ti_cleared", {31'd0, tmp[30]}, 32'd0);

    // eret, then eret losing to an interrupt
    mtc0(5'd14, 32'hBFC0_0200);
    valid_m = 1; eret_m = 1;
    #1;
    check_eq("eret_flush", {31'd0, except_flush}, 32'd1);
    check_eq("eret_pc", except_pc, 32'hBFC0_0200);
    step();
    idle();
    #1 check_eq("eret_exl", {31'd0, status_out[1]}, 32'd0);
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'd1;
    step();
    valid_m = 1; eret_m = 1; pc_m = 32'hBFC0_0400;
    #1;
    check_eq("eret_int_flush", {31'd0, except_flush}, 32'd1);
    check_eq("eret_int_pc", except_pc, EXC_VEC);
    step();
    idle(); hw_int = 0;
    #1 tmp = cp0_rdata_e;
    check_eq("eret_int_code", {27'd0, tmp[6:2]}, 32'h00);

    // stalled syscall is held until the stall drops
    valid_m = 1; stall_m = 1; syscall_m = 1; pc_m = 32'hBFC0_0500;
    #1 check_eq("stall_flush", {31'd0, except_flush}, 32'd0);
    step();
    #1;
    check_eq("stall_epc", epc_out, 32'hBFC0_0400);
    check_eq("stall_status", status_out, 32'h0040_0403);
    stall_m = 0;
    #1 check_eq("unstall_flush", {31'd0, except_flush}, 32'd1);
    step();
    idle();
    #1 tmp = cp0_rdata_e;
    check_eq("unstall_code", {27'd0, tmp[6:2]}, 32'h08);
    check_eq("unstall_epc", epc_out, 32'hBFC0_0400);

    // random traffic against the model
    repeat (1500) random_cycle();
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
